// File: rtl/control_sequencer_pkg.sv
// Shared constants for the microcoded controller: opcode map, T-state
// encodings and bit positions of the packed 16-bit control word.
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    T0     = 3'd0,
    T1     = 3'd1,
    T2     = 3'd2,
    T3     = 3'd3,
    T4     = 3'd4,
    T_HALT = 3'd5
  } tstate_e;

  localparam int CW_WIDTH = 16;
  typedef logic [CW_WIDTH-1:0] ctrl_word_t;

  localparam int CW_PC_OUT     = 0;
  localparam int CW_PC_INC     = 1;
  localparam int CW_PC_LOAD    = 2;
  localparam int CW_MAR_LOAD   = 3;
  localparam int CW_RAM_OUT    = 4;
  localparam int CW_RAM_WE     = 5;
  localparam int CW_IR_LOAD    = 6;
  localparam int CW_IR_OUT     = 7;
  localparam int CW_A_LOAD     = 8;
  localparam int CW_A_OUT      = 9;
  localparam int CW_B_LOAD     = 10;
  localparam int CW_ALU_OUT    = 11;
  localparam int CW_ALU_SUB    = 12;
  localparam int CW_FLAGS_LOAD = 13;
  localparam int CW_OUT_LOAD   = 14;

endpackage

// File: rtl/control_sequencer_if.sv
// Controller-to-datapath signal bundle: master is the sequencer, slave is
// the register/RAM side that consumes the strobes.
interface control_sequencer_if;
  logic       run;
  logic [3:0] ir_opcode;
  logic       flag_c;
  logic       flag_z;

  logic       pc_out;
  logic       pc_inc;
  logic       pc_load;
  logic       mar_load;
  logic       ram_out;
  logic       ram_we;
  logic       ir_load;
  logic       ir_out;
  logic       a_load;
  logic       a_out;
  logic       b_load;
  logic       alu_out;
  logic       alu_sub;
  logic       flags_load;
  logic       out_load;
  logic       halted;
  logic [2:0] tstate;

  modport master (
    input  run, ir_opcode, flag_c, flag_z,
    output pc_out, pc_inc, pc_load, mar_load, ram_out, ram_we, ir_load,
           ir_out, a_load, a_out, b_load, alu_out, alu_sub, flags_load,
           out_load, halted, tstate
  );

  modport slave (
    output run, ir_opcode, flag_c, flag_z,
    input  pc_out, pc_inc, pc_load, mar_load, ram_out, ram_we, ir_load,
           ir_out, a_load, a_out, b_load, alu_out, alu_sub, flags_load,
           out_load, halted, tstate
  );
endinterface

// File: rtl/control_sequencer_tstate_counter.sv
// T-state register: advances when run=1, wraps to T0 at end of an
// instruction, and parks in T_HALT until reset.
module tstate_counter
  import cpu_ctrl_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    run,
  input  logic    instr_end,
  input  logic    halt_req,
  output tstate_e state
);

  tstate_e state_next;

  // NOTE: sequential state uses non-blocking assignment so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= T0;
    else       state <= state_next;
  end

  // NOTE: hold is the default assignment, so no path leaves state_next
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    if (run && state != T_HALT) begin
      if (halt_req)       state_next = T_HALT;
      else if (instr_end) state_next = T0;
      else begin
        case (state)
          T0:      state_next = T1;
          T1:      state_next = T2;
          T2:      state_next = T3;
          T3:      state_next = T4;
          default: state_next = T0;
        endcase
      end
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Decodes T-state and opcode into the datapath strobes; strobes are forced
// low while in reset, frozen (run=0) or halted.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  control_sequencer_if.master  bus
);

  tstate_e    state;
  logic       instr_end;
  logic       halt_req;
  ctrl_word_t cw;
  ctrl_word_t cw_gated;

  tstate_counter u_tstate (
    .clk       (clk),
    .reset     (reset),
    .run       (bus.run),
    .instr_end (instr_end),
    .halt_req  (halt_req),
    .state     (state)
  );

  always_comb begin
    cw        = '0;
    instr_end = 1'b0;
    halt_req  = 1'b0;
    case (state)
      T0: begin
        cw[CW_PC_OUT]   = 1'b1;
        cw[CW_MAR_LOAD] = 1'b1;
      end
      T1: begin
        cw[CW_RAM_OUT] = 1'b1;
        cw[CW_IR_LOAD] = 1'b1;
        cw[CW_PC_INC]  = 1'b1;
      end
      T2: begin
        case (bus.ir_opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw[CW_IR_OUT]   = 1'b1;
            cw[CW_MAR_LOAD] = 1'b1;
          end
          OP_LDI: begin
            cw[CW_IR_OUT] = 1'b1;
            cw[CW_A_LOAD] = 1'b1;
            instr_end     = 1'b1;
          end
          OP_JMP: begin
            cw[CW_IR_OUT]  = 1'b1;
            cw[CW_PC_LOAD] = 1'b1;
            instr_end      = 1'b1;
          end
          OP_JC: begin
            cw[CW_IR_OUT]  = 1'b1;
            cw[CW_PC_LOAD] = bus.flag_c;
            instr_end      = 1'b1;
          end
          OP_JZ: begin
            cw[CW_IR_OUT]  = 1'b1;
            cw[CW_PC_LOAD] = bus.flag_z;
            instr_end      = 1'b1;
          end
          OP_OUT: begin
            cw[CW_A_OUT]    = 1'b1;
            cw[CW_OUT_LOAD] = 1'b1;
            instr_end       = 1'b1;
          end
          OP_HLT:  halt_req  = 1'b1;
          default: instr_end = 1'b1;
        endcase
      end
      T3: begin
        case (bus.ir_opcode)
          OP_LDA: begin
            cw[CW_RAM_OUT] = 1'b1;
            cw[CW_A_LOAD]  = 1'b1;
            instr_end      = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw[CW_RAM_OUT] = 1'b1;
            cw[CW_B_LOAD]  = 1'b1;
          end
          OP_STA: begin
            cw[CW_A_OUT]  = 1'b1;
            cw[CW_RAM_WE] = 1'b1;
            instr_end     = 1'b1;
          end
          default: instr_end = 1'b1;
        endcase
      end
      T4: begin
        if (bus.ir_opcode == OP_ADD || bus.ir_opcode == OP_SUB) begin
          cw[CW_ALU_OUT]    = 1'b1;
          cw[CW_A_LOAD]     = 1'b1;
          cw[CW_FLAGS_LOAD] = 1'b1;
          cw[CW_ALU_SUB]    = (bus.ir_opcode == OP_SUB);
        end
        instr_end = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset gating keeps the T0 fetch strobes quiet while reset is held.
  assign cw_gated = (bus.run && !reset) ? cw : '0;

  assign bus.pc_out     = cw_gated[CW_PC_OUT];
  assign bus.pc_inc     = cw_gated[CW_PC_INC];
  assign bus.pc_load    = cw_gated[CW_PC_LOAD];
  assign bus.mar_load   = cw_gated[CW_MAR_LOAD];
  assign bus.ram_out    = cw_gated[CW_RAM_OUT];
  assign bus.ram_we     = cw_gated[CW_RAM_WE];
  assign bus.ir_load    = cw_gated[CW_IR_LOAD];
  assign bus.ir_out     = cw_gated[CW_IR_OUT];
  assign bus.a_load     = cw_gated[CW_A_LOAD];
  assign bus.a_out      = cw_gated[CW_A_OUT];
  assign bus.b_load     = cw_gated[CW_B_LOAD];
  assign bus.alu_out    = cw_gated[CW_ALU_OUT];
  assign bus.alu_sub    = cw_gated[CW_ALU_SUB];
  assign bus.flags_load = cw_gated[CW_FLAGS_LOAD];
  assign bus.out_load   = cw_gated[CW_OUT_LOAD];
  assign bus.halted     = (state == T_HALT);
  assign bus.tstate     = state;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed and constrained-random bench for control_sequencer; inputs change
// 1 ns after the rising edge and outputs are sampled 1 ns later.
module tb_control_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  control_sequencer_if bus ();

  control_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Strobe vector order, MSB first: pc_out pc_inc pc_load mar_load ram_out
  // ram_we ir_load ir_out a_load a_out b_load alu_out alu_sub flags_load out_load
  localparam logic [14:0] S_PC_OUT     = 15'h4000;
  localparam logic [14:0] S_PC_INC     = 15'h2000;
  localparam logic [14:0] S_PC_LOAD    = 15'h1000;
  localparam logic [14:0] S_MAR_LOAD   = 15'h0800;
  localparam logic [14:0] S_RAM_OUT    = 15'h0400;
  localparam logic [14:0] S_RAM_WE     = 15'h0200;
  localparam logic [14:0] S_IR_LOAD    = 15'h0100;
  localparam logic [14:0] S_IR_OUT     = 15'h0080;
  localparam logic [14:0] S_A_LOAD     = 15'h0040;
  localparam logic [14:0] S_A_OUT      = 15'h0020;
  localparam logic [14:0] S_B_LOAD     = 15'h0010;
  localparam logic [14:0] S_ALU_OUT    = 15'h0008;
  localparam logic [14:0] S_ALU_SUB    = 15'h0004;
  localparam logic [14:0] S_FLAGS_LOAD = 15'h0002;
  localparam logic [14:0] S_OUT_LOAD   = 15'h0001;
  localparam logic [14:0] FETCH0 = S_PC_OUT | S_MAR_LOAD;
  localparam logic [14:0] FETCH1 = S_RAM_OUT | S_IR_LOAD | S_PC_INC;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  op;
    int          len;
    logic        fc;
    logic        fz;
    logic [14:0] t2;
    logic [14:0] t3;
    logic [14:0] t4;
  } tc_t;

  function automatic logic [14:0] strobes();
    return {bus.pc_out, bus.pc_inc, bus.pc_load, bus.mar_load, bus.ram_out,
            bus.ram_we, bus.ir_load, bus.ir_out, bus.a_load, bus.a_out,
            bus.b_load, bus.alu_out, bus.alu_sub, bus.flags_load, bus.out_load};
  endfunction

  function automatic int instr_len(logic [3:0] op);
    if (op == 4'h1 || op == 4'h4) return 4;
    if (op == 4'h2 || op == 4'h3) return 5;
    return 3;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.run = 1'b1;
    bus.ir_opcode = 4'h0;
    bus.flag_c = 1'b0;
    bus.flag_z = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      #1;
      n_assert++;
      if (strobes() !== 15'h0 || bus.tstate !== 3'd0 || bus.halted !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: strobes=%h tstate=%0d halted=%b, required strobes=0 tstate=0 halted=0",
                 i, strobes(), bus.tstate, bus.halted);
      end
    end
    step();
    reset = 1'b0;
    #1;
    n_assert++;
    if (bus.tstate !== 3'd0 || strobes() !== FETCH0) begin
      n_fail++;
      $display("FAIL reset_release: tstate=%0d strobes=%h, required tstate=0 strobes=%h",
               bus.tstate, strobes(), FETCH0);
    end
  endtask

  task automatic test_ldi();
    logic [14:0] exp_s [3];
    exp_s[0] = FETCH0;
    exp_s[1] = FETCH1;
    exp_s[2] = S_IR_OUT | S_A_LOAD;
    bus.ir_opcode = 4'h5;
    #1;
    for (int t = 0; t < 3; t++) begin
      n_assert++;
      if (bus.tstate !== 3'(t) || strobes() !== exp_s[t]) begin
        n_fail++;
        $display("FAIL ldi_T%0d: tstate=%0d strobes=%h, required tstate=%0d strobes=%h",
                 t, bus.tstate, strobes(), t, exp_s[t]);
      end
      step();
    end
    n_assert++;
    if (bus.tstate !== 3'd0) begin
      n_fail++;
      $display("FAIL ldi_wrap: tstate=%0d, required 0", bus.tstate);
    end
  endtask

  task automatic test_sub();
    logic [14:0] exp_s [5];
    exp_s[0] = FETCH0;
    exp_s[1] = FETCH1;
    exp_s[2] = S_IR_OUT | S_MAR_LOAD;
    exp_s[3] = S_RAM_OUT | S_B_LOAD;
    exp_s[4] = S_ALU_OUT | S_A_LOAD | S_FLAGS_LOAD | S_ALU_SUB;
    bus.ir_opcode = 4'h3;
    #1;
    for (int t = 0; t < 5; t++) begin
      n_assert++;
      if (bus.tstate !== 3'(t) || strobes() !== exp_s[t]) begin
        n_fail++;
        $display("FAIL sub_T%0d: tstate=%0d strobes=%h, required tstate=%0d strobes=%h",
                 t, bus.tstate, strobes(), t, exp_s[t]);
      end
      step();
    end
    n_assert++;
    if (bus.tstate !== 3'd0) begin
      n_fail++;
      $display("FAIL sub_wrap: tstate=%0d, required 0", bus.tstate);
    end
  endtask

  task automatic test_cond_jump();
    logic [14:0] exp_t2;
    for (int k = 0; k < 4; k++) begin
      bus.ir_opcode = (k < 2) ? 4'h7 : 4'h8;
      bus.flag_c = (k == 1) || (k == 2);
      bus.flag_z = (k == 3) || (k == 0);
      exp_t2 = (k == 1 || k == 3) ? (S_IR_OUT | S_PC_LOAD) : S_IR_OUT;
      #1;
      n_assert++;
      if (bus.tstate !== 3'd0 || strobes() !== FETCH0) begin
        n_fail++;
        $display("FAIL jump%0d_T0: tstate=%0d strobes=%h, required tstate=0 strobes=%h",
                 k, bus.tstate, strobes(), FETCH0);
      end
      step();
      step();
      n_assert++;
      if (bus.tstate !== 3'd2 || strobes() !== exp_t2) begin
        n_fail++;
        $display("FAIL jump%0d_T2: tstate=%0d strobes=%h, required tstate=2 strobes=%h",
                 k, bus.tstate, strobes(), exp_t2);
      end
      step();
      n_assert++;
      if (bus.tstate !== 3'd0) begin
        n_fail++;
        $display("FAIL jump%0d_len: tstate=%0d, required 0", k, bus.tstate);
      end
    end
    bus.flag_c = 1'b0;
    bus.flag_z = 1'b0;
  endtask

  task automatic test_opcodes();
    tc_t tbl [10];
    logic [14:0] exp_s;
    tbl = '{
      '{4'h0, 3, 1'b0, 1'b0, 15'h0, 15'h0, 15'h0},
      '{4'h1, 4, 1'b0, 1'b0, S_IR_OUT | S_MAR_LOAD, S_RAM_OUT | S_A_LOAD, 15'h0},
      '{4'h2, 5, 1'b1, 1'b1, S_IR_OUT | S_MAR_LOAD, S_RAM_OUT | S_B_LOAD,
        S_ALU_OUT | S_A_LOAD | S_FLAGS_LOAD},
      '{4'h4, 4, 1'b0, 1'b0, S_IR_OUT | S_MAR_LOAD, S_A_OUT | S_RAM_WE, 15'h0},
      '{4'h6, 3, 1'b0, 1'b0, S_IR_OUT | S_PC_LOAD, 15'h0, 15'h0},
      '{4'h8, 3, 1'b1, 1'b0, S_IR_OUT, 15'h0, 15'h0},
      '{4'hE, 3, 1'b0, 1'b0, S_A_OUT | S_OUT_LOAD, 15'h0, 15'h0},
      '{4'h9, 3, 1'b1, 1'b1, 15'h0, 15'h0, 15'h0},
      '{4'hB, 3, 1'b0, 1'b0, 15'h0, 15'h0, 15'h0},
      '{4'hD, 3, 1'b1, 1'b1, 15'h0, 15'h0, 15'h0}
    };
    foreach (tbl[n]) begin
      bus.ir_opcode = tbl[n].op;
      bus.flag_c = tbl[n].fc;
      bus.flag_z = tbl[n].fz;
      #1;
      for (int t = 0; t < tbl[n].len; t++) begin
        case (t)
          0:       exp_s = FETCH0;
          1:       exp_s = FETCH1;
          2:       exp_s = tbl[n].t2;
          3:       exp_s = tbl[n].t3;
          default: exp_s = tbl[n].t4;
        endcase
        n_assert++;
        if (bus.tstate !== 3'(t) || strobes() !== exp_s) begin
          n_fail++;
          $display("FAIL op%h_T%0d: tstate=%0d strobes=%h, required tstate=%0d strobes=%h",
                   tbl[n].op, t, bus.tstate, strobes(), t, exp_s);
        end
        step();
      end
      n_assert++;
      if (bus.tstate !== 3'd0) begin
        n_fail++;
        $display("FAIL op%h_len: tstate=%0d, required 0", tbl[n].op, bus.tstate);
      end
    end
    bus.flag_c = 1'b0;
    bus.flag_z = 1'b0;
  endtask

  task automatic test_halt();
    bus.ir_opcode = 4'hF;
    step();
    step();
    n_assert++;
    if (bus.tstate !== 3'd2 || strobes() !== 15'h0 || bus.halted !== 1'b0) begin
      n_fail++;
      $display("FAIL hlt_T2: tstate=%0d strobes=%h halted=%b, required tstate=2 strobes=0 halted=0",
               bus.tstate, strobes(), bus.halted);
    end
    for (int i = 0; i < 21; i++) begin
      step();
      bus.run = (i % 3 != 1);
      #1;
      n_assert++;
      if (bus.tstate !== 3'd5 || strobes() !== 15'h0 || bus.halted !== 1'b1) begin
        n_fail++;
        $display("FAIL halted[%0d]: tstate=%0d strobes=%h halted=%b, required tstate=5 strobes=0 halted=1",
                 i, bus.tstate, strobes(), bus.halted);
      end
    end
    bus.run = 1'b1;
    reset = 1'b1;
    #1;
    n_assert++;
    if (bus.tstate !== 3'd0 || strobes() !== 15'h0 || bus.halted !== 1'b0) begin
      n_fail++;
      $display("FAIL hlt_reset: tstate=%0d strobes=%h halted=%b, required tstate=0 strobes=0 halted=0",
               bus.tstate, strobes(), bus.halted);
    end
    step();
    reset = 1'b0;
    bus.ir_opcode = 4'h0;
  endtask

  task automatic test_freeze();
    bus.ir_opcode = 4'h2;
    step();
    step();
    step();
    n_assert++;
    if (bus.tstate !== 3'd3 || strobes() !== (S_RAM_OUT | S_B_LOAD)) begin
      n_fail++;
      $display("FAIL freeze_pre: tstate=%0d strobes=%h, required tstate=3 strobes=%h",
               bus.tstate, strobes(), S_RAM_OUT | S_B_LOAD);
    end
    bus.run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_assert++;
      if (bus.tstate !== 3'd3 || strobes() !== 15'h0) begin
        n_fail++;
        $display("FAIL freeze[%0d]: tstate=%0d strobes=%h, required tstate=3 strobes=0",
                 i, bus.tstate, strobes());
      end
      step();
    end
    bus.run = 1'b1;
    #1;
    n_assert++;
    if (bus.tstate !== 3'd3 || strobes() !== (S_RAM_OUT | S_B_LOAD)) begin
      n_fail++;
      $display("FAIL resume_T3: tstate=%0d strobes=%h, required tstate=3 strobes=%h",
               bus.tstate, strobes(), S_RAM_OUT | S_B_LOAD);
    end
    step();
    n_assert++;
    if (bus.tstate !== 3'd4 || strobes() !== (S_ALU_OUT | S_A_LOAD | S_FLAGS_LOAD)) begin
      n_fail++;
      $display("FAIL resume_T4: tstate=%0d strobes=%h, required tstate=4 strobes=%h",
               bus.tstate, strobes(), S_ALU_OUT | S_A_LOAD | S_FLAGS_LOAD);
    end
    step();
  endtask

  task automatic test_async_reset();
    bus.ir_opcode = 4'h4;
    step();
    step();
    #1;
    n_assert++;
    if (bus.tstate !== 3'd2 || strobes() !== (S_IR_OUT | S_MAR_LOAD)) begin
      n_fail++;
      $display("FAIL sta_T2: tstate=%0d strobes=%h, required tstate=2 strobes=%h",
               bus.tstate, strobes(), S_IR_OUT | S_MAR_LOAD);
    end
    #1;
    reset = 1'b1;
    #1;
    n_assert++;
    if (bus.tstate !== 3'd0 || strobes() !== 15'h0) begin
      n_fail++;
      $display("FAIL async_reset: tstate=%0d strobes=%h, required tstate=0 strobes=0",
               bus.tstate, strobes());
    end
    step();
    n_assert++;
    if (bus.ram_we !== 1'b0 || bus.tstate !== 3'd0) begin
      n_fail++;
      $display("FAIL async_hold: ram_we=%b tstate=%0d, required ram_we=0 tstate=0",
               bus.ram_we, bus.tstate);
    end
    reset = 1'b0;
    #1;
    n_assert++;
    if (bus.tstate !== 3'd0 || strobes() !== FETCH0) begin
      n_fail++;
      $display("FAIL async_release: tstate=%0d strobes=%h, required tstate=0 strobes=%h",
               bus.tstate, strobes(), FETCH0);
    end
    step();
    step();
    step();
    n_assert++;
    if (bus.tstate !== 3'd3 || strobes() !== (S_A_OUT | S_RAM_WE)) begin
      n_fail++;
      $display("FAIL sta_rerun_T3: tstate=%0d strobes=%h, required tstate=3 strobes=%h",
               bus.tstate, strobes(), S_A_OUT | S_RAM_WE);
    end
    step();
  endtask

  task automatic test_random();
    logic [2:0] model_t;
    int drivers;
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_t = 3'd0;
    for (int i = 0; i < 10000; i++) begin
      if (model_t == 3'd0) bus.ir_opcode = 4'($urandom_range(0, 15));
      bus.flag_c = 1'($urandom_range(0, 1));
      bus.flag_z = 1'($urandom_range(0, 1));
      bus.run = ($urandom_range(0, 3) != 0);
      reset = (model_t == 3'd5 && $urandom_range(0, 3) == 0) || ($urandom_range(0, 499) == 0);
      if (reset) model_t = 3'd0;
      #1;
      drivers = int'(bus.pc_out) + int'(bus.ram_out) + int'(bus.ir_out) +
                int'(bus.a_out) + int'(bus.alu_out);
      n_assert++;
      if (bus.tstate !== model_t || bus.halted !== (model_t == 3'd5)) begin
        n_fail++;
        $display("FAIL rand_state[%0d]: tstate=%0d halted=%b, required tstate=%0d halted=%b",
                 i, bus.tstate, bus.halted, model_t, model_t == 3'd5);
      end
      n_assert++;
      if (drivers > 1) begin
        n_fail++;
        $display("FAIL rand_bus[%0d]: %0d bus drivers, required at most 1", i, drivers);
      end
      n_assert++;
      if (bus.ram_we === 1'b1 && bus.ram_out === 1'b1) begin
        n_fail++;
        $display("FAIL rand_ram[%0d]: ram_we=1 ram_out=1, required not both", i);
      end
      n_assert++;
      if ((reset || !bus.run || model_t == 3'd5) && strobes() !== 15'h0) begin
        n_fail++;
        $display("FAIL rand_gate[%0d]: strobes=%h, required 0", i, strobes());
      end
      if (!reset && model_t != 3'd5 && bus.run) begin
        if (model_t < 3'd2)                              model_t = model_t + 3'd1;
        else if (model_t == 3'd2 && bus.ir_opcode == 4'hF) model_t = 3'd5;
        else if (int'(model_t) + 1 >= instr_len(bus.ir_opcode)) model_t = 3'd0;
        else                                             model_t = model_t + 3'd1;
      end
      step();
    end
    reset = 1'b0;
    bus.run = 1'b1;
  endtask

  initial begin
    bus.run = 1'b0;
    bus.ir_opcode = 4'h0;
    bus.flag_c = 1'b0;
    bus.flag_z = 1'b0;
    test_reset();
    test_ldi();
    test_sub();
    test_cond_jump();
    test_opcodes();
    test_freeze();
    test_async_reset();
    test_halt();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
